// File: rtl/gcn_sched_pkg.sv
// Shared types and default parameter values for the GCN job scheduler.
package gcn_sched_pkg;

    localparam int DEF_FEATURE_ROWS      = 6;
    localparam int DEF_MAX_ADDRESS_WIDTH = 2;
    localparam int DEF_ADDRESS_WIDTH     = 13;
    localparam int DEF_ID_WIDTH          = 4;
    localparam int DEF_JOB_DEPTH         = 4;
    localparam int DEF_TIMEOUT_CYCLES    = 4096;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_ABORT,
        S_REPORT
    } sched_state_e;

    // Queue entry at the default widths; the scheduler re-declares it with its own parameters.
    typedef struct packed {
        logic [DEF_ADDRESS_WIDTH-1:0] base;
        logic [DEF_ID_WIDTH-1:0]      id;
    } job_entry_t;

endpackage

// File: rtl/gcn_job_scheduler_if.sv
// Job request, GCN core control and result signals of the scheduler.
// slave is the scheduler's view, master the job source / core / consumer side.
interface gcn_job_scheduler_if
    import gcn_sched_pkg::*;
#(
    parameter int FEATURE_ROWS      = DEF_FEATURE_ROWS,
    parameter int MAX_ADDRESS_WIDTH = DEF_MAX_ADDRESS_WIDTH,
    parameter int ADDRESS_WIDTH     = DEF_ADDRESS_WIDTH,
    parameter int ID_WIDTH          = DEF_ID_WIDTH
) ();

    logic                                        job_valid;
    logic                                        job_ready;
    logic [ADDRESS_WIDTH-1:0]                    job_base;
    logic [ID_WIDTH-1:0]                         job_id;
    logic                                        gcn_start;
    logic                                        gcn_soft_reset;
    logic                                        gcn_done;
    logic [ADDRESS_WIDTH-1:0]                    gcn_read_address;
    logic [ADDRESS_WIDTH-1:0]                    mem_address;
    logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0] gcn_result;
    logic                                        res_valid;
    logic                                        res_ready;
    logic [ID_WIDTH-1:0]                         res_id;
    logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0] res_data;
    logic                                        res_timeout;
    logic                                        busy;

    modport slave (
        input  job_valid, job_base, job_id, gcn_done, gcn_read_address, gcn_result, res_ready,
        output job_ready, gcn_start, gcn_soft_reset, mem_address, res_valid, res_id, res_data,
               res_timeout, busy
    );

    modport master (
        output job_valid, job_base, job_id, gcn_done, gcn_read_address, gcn_result, res_ready,
        input  job_ready, gcn_start, gcn_soft_reset, mem_address, res_valid, res_id, res_data,
               res_timeout, busy
    );

endinterface

// File: rtl/gcn_job_fifo.sv
// Power-of-two deep job queue; a push into a full queue is dropped even if a pop
// happens in the same cycle.
module gcn_job_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  T     wdata,
    input  logic pop,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);

    T             mem_q [DEPTH];
    T             mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (PW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/gcn_job_scheduler.sv
// Queues GCN jobs, launches them one at a time on the core, supervises completion
// with a timeout abort, and reports each job's argmax results with its tag.
module gcn_job_scheduler
    import gcn_sched_pkg::*;
#(
    parameter int FEATURE_ROWS      = DEF_FEATURE_ROWS,
    parameter int MAX_ADDRESS_WIDTH = DEF_MAX_ADDRESS_WIDTH,
    parameter int ADDRESS_WIDTH     = DEF_ADDRESS_WIDTH,
    parameter int ID_WIDTH          = DEF_ID_WIDTH,
    parameter int JOB_DEPTH         = DEF_JOB_DEPTH,
    parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    gcn_job_scheduler_if.slave  bus
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] base;
        logic [ID_WIDTH-1:0]      id;
    } job_t;

    typedef logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0] result_t;

    sched_state_e             state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] base_q, base_d;
    logic [ID_WIDTH-1:0]      id_q, id_d;
    logic [ID_WIDTH-1:0]      res_id_q, res_id_d;
    result_t                  res_data_q, res_data_d;
    logic                     res_timeout_q, res_timeout_d;

    logic fifo_push, fifo_pop, fifo_full, fifo_empty;
    job_t fifo_wdata, fifo_rdata;
    logic start, soft_reset, res_valid;

    assign fifo_wdata = '{base: bus.job_base, id: bus.job_id};
    assign fifo_push  = bus.job_valid && !fifo_full;

    gcn_job_fifo #(
        .T     (job_t),
        .DEPTH (JOB_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        base_d        = base_q;
        id_d          = id_q;
        res_id_d      = res_id_q;
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;
        fifo_pop      = 1'b0;
        start         = 1'b0;
        soft_reset    = 1'b0;
        res_valid     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                fifo_pop = 1'b1;
                start    = 1'b1;
                base_d   = fifo_rdata.base;
                id_d     = fifo_rdata.id;
                cnt_d    = '0;
                state_d  = S_RUN;
            end
            S_RUN: begin
                // cnt_q == 0 marks the first RUN cycle, where gcn_done may still be the previous job's level.
                if (cnt_q != '0 && bus.gcn_done) begin
                    res_data_d    = bus.gcn_result;
                    res_timeout_d = 1'b0;
                    res_id_d      = id_q;
                    state_d       = S_REPORT;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ABORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ABORT: begin
                soft_reset    = 1'b1;
                res_data_d    = '0;
                res_timeout_d = 1'b1;
                res_id_d      = id_q;
                state_d       = S_REPORT;
            end
            S_REPORT: begin
                res_valid = 1'b1;
                if (bus.res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            base_q        <= '0;
            id_q          <= '0;
            res_id_q      <= '0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            base_q        <= base_d;
            id_q          <= id_d;
            res_id_q      <= res_id_d;
            res_data_q    <= res_data_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign bus.job_ready      = !fifo_full;
    assign bus.gcn_start      = start;
    assign bus.gcn_soft_reset = soft_reset;
    assign bus.mem_address    = (state_q == S_IDLE) ? bus.gcn_read_address
                                                    : base_q + bus.gcn_read_address;
    assign bus.res_valid      = res_valid;
    assign bus.res_id         = res_id_q;
    assign bus.res_data       = res_data_q;
    assign bus.res_timeout    = res_timeout_q;
    assign bus.busy           = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_gcn_job_scheduler.sv
// Directed bench for gcn_job_scheduler: one default instance and one with a
// 16-cycle timeout, results checked against a scoreboard filled at job push.
module tb_gcn_job_scheduler;
    import gcn_sched_pkg::*;

    typedef logic [DEF_FEATURE_ROWS*DEF_MAX_ADDRESS_WIDTH-1:0] res_t;
    typedef struct {
        job_entry_t job;
        res_t       data;
        logic       to;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t sb_b[$];
    exp_t cur;

    always #5 clk = ~clk;

    gcn_job_scheduler_if bus_a ();
    gcn_job_scheduler_if bus_b ();

    gcn_job_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    gcn_job_scheduler #(.TIMEOUT_CYCLES(16)) dut_to (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t pat(input logic [3:0] id);
        return {id, ~id, id ^ 4'h5};
    endfunction

    function automatic exp_t mk(input logic [12:0] base, input logic [3:0] id, input logic to);
        exp_t e;
        e.job.base = base;
        e.job.id   = id;
        e.data     = to ? '0 : pat(id);
        e.to       = to;
        return e;
    endfunction

    task automatic expect_result();
        int n;
        n = 0;
        while (bus_a.res_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("res_valid_seen", 64'(bus_a.res_valid), 64'(1));
        chk("sb_has_entry", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            chk("res_id", 64'(bus_a.res_id), 64'(cur.job.id));
            chk("res_data", 64'(bus_a.res_data), 64'(cur.data));
            chk("res_timeout", 64'(bus_a.res_timeout), 64'(cur.to));
        end
    endtask

    task automatic hold_check(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("hold_valid", 64'(bus_a.res_valid), 64'(1));
            chk("hold_id", 64'(bus_a.res_id), 64'(cur.job.id));
            chk("hold_data", 64'(bus_a.res_data), 64'(cur.data));
            chk("hold_no_start", 64'(bus_a.gcn_start), 64'(0));
        end
    endtask

    task automatic handshake();
        bus_a.res_ready = 1'b1;
        tick();
        bus_a.res_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_start"}, 64'(bus_a.gcn_start), 64'(0));
        chk({tag, "_soft"}, 64'(bus_a.gcn_soft_reset), 64'(0));
        chk({tag, "_valid"}, 64'(bus_a.res_valid), 64'(0));
        chk({tag, "_busy"}, 64'(bus_a.busy), 64'(0));
        chk({tag, "_ready"}, 64'(bus_a.job_ready), 64'(1));
        chk({tag, "_res_id"}, 64'(bus_a.res_id), 64'(0));
        chk({tag, "_res_data"}, 64'(bus_a.res_data), 64'(0));
        chk({tag, "_res_to"}, 64'(bus_a.res_timeout), 64'(0));
        chk({tag, "_mem"}, 64'(bus_a.mem_address), 64'(bus_a.gcn_read_address));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int soft_cnt, soft_first, vld_first, start_cnt;
        exp_t eb;

        reset = 1'b0;
        bus_a.job_valid = 1'b0; bus_a.job_base = '0; bus_a.job_id = '0;
        bus_a.gcn_done = 1'b0; bus_a.gcn_read_address = 13'h55; bus_a.gcn_result = '0;
        bus_a.res_ready = 1'b0;
        bus_b.job_valid = 1'b0; bus_b.job_base = '0; bus_b.job_id = '0;
        bus_b.gcn_done = 1'b0; bus_b.gcn_read_address = '0; bus_b.gcn_result = '0;
        bus_b.res_ready = 1'b0;
        tick();
        tick();
        check_reset_outputs("por");
        reset = 1'b1;
        tick();

        // Single job: start two cycles after push, done 20 cycles after start.
        bus_a.job_valid = 1'b1; bus_a.job_base = 13'h100; bus_a.job_id = 4'd3;
        sb.push_back(mk(13'h100, 4'd3, 1'b0));
        tick();
        bus_a.job_valid = 1'b0;
        chk("start_n1", 64'(bus_a.gcn_start), 64'(0));
        tick();
        chk("start_n2", 64'(bus_a.gcn_start), 64'(1));
        tick();
        chk("start_one_cycle", 64'(bus_a.gcn_start), 64'(0));
        bus_a.gcn_read_address = 13'h23;
        #1;
        chk("mem_addr_offset", 64'(bus_a.mem_address), 64'(13'h123));
        repeat (19) tick();
        bus_a.gcn_done = 1'b1; bus_a.gcn_result = pat(4'd3);
        expect_result();
        bus_a.gcn_done = 1'b0;

        // Fill the queue while the result sits unacknowledged; the fifth push is refused.
        for (int k = 0; k < 5; k++) begin
            chk("job_ready_fill", 64'(bus_a.job_ready), 64'(k < 4));
            bus_a.job_valid = 1'b1;
            bus_a.job_base  = 13'h200 + 13'(k * 16);
            bus_a.job_id    = 4'(k);
            if (k < 4) sb.push_back(mk(13'h200 + 13'(k * 16), 4'(k), 1'b0));
            tick();
            chk("report_hold_id", 64'(bus_a.res_id), 64'(3));
            chk("report_hold_valid", 64'(bus_a.res_valid), 64'(1));
            chk("no_start_in_report", 64'(bus_a.gcn_start), 64'(0));
        end
        bus_a.job_valid = 1'b0;
        chk("busy_full", 64'(bus_a.busy), 64'(1));
        hold_check(5);
        handshake();

        for (int j = 0; j < 4; j++) begin
            chk("bubble_no_start", 64'(bus_a.gcn_start), 64'(0));
            tick();
            chk("start_after_bubble", 64'(bus_a.gcn_start), 64'(1));
            tick();
            bus_a.gcn_read_address = 13'h7;
            #1;
            if (sb.size() != 0)
                chk("mem_addr_job", 64'(bus_a.mem_address), 64'(13'(sb[0].job.base + 13'h7)));
            repeat (4) tick();
            bus_a.gcn_done = 1'b1;
            if (sb.size() != 0) bus_a.gcn_result = pat(sb[0].job.id);
            expect_result();
            bus_a.gcn_done = 1'b0;
            handshake();
        end
        tick();
        chk("refused_job_absent_start", 64'(bus_a.gcn_start), 64'(0));
        chk("refused_job_absent_busy", 64'(bus_a.busy), 64'(0));

        // Address wrap, then gcn_done held high across two jobs.
        bus_a.gcn_read_address = 13'h20;
        #1;
        chk("mem_addr_idle", 64'(bus_a.mem_address), 64'(13'h20));
        bus_a.job_valid = 1'b1; bus_a.job_base = 13'h1FF0; bus_a.job_id = 4'd5;
        sb.push_back(mk(13'h1FF0, 4'd5, 1'b0));
        tick();
        bus_a.job_base = 13'h0; bus_a.job_id = 4'd6;
        sb.push_back(mk(13'h0, 4'd6, 1'b0));
        tick();
        bus_a.job_valid = 1'b0;
        chk("start_wrap_job", 64'(bus_a.gcn_start), 64'(1));
        tick();
        chk("mem_addr_wrap", 64'(bus_a.mem_address), 64'(13'h0010));
        bus_a.gcn_done = 1'b1; bus_a.gcn_result = pat(4'd5);
        expect_result();
        bus_a.gcn_result = pat(4'd6);
        handshake();
        chk("mem_addr_idle2", 64'(bus_a.mem_address), 64'(13'h20));
        chk("stale_no_start", 64'(bus_a.gcn_start), 64'(0));
        tick();
        chk("stale_start", 64'(bus_a.gcn_start), 64'(1));
        tick();
        chk("stale_run0", 64'(bus_a.res_valid), 64'(0));
        tick();
        chk("stale_done_ignored", 64'(bus_a.res_valid), 64'(0));
        tick();
        chk("done_second_run_cycle", 64'(bus_a.res_valid), 64'(1));
        expect_result();
        bus_a.gcn_done = 1'b0;
        handshake();

        // Timeout instance: no done, abort after 16 RUN cycles.
        bus_b.job_valid = 1'b1; bus_b.job_base = 13'h40; bus_b.job_id = 4'd9;
        sb_b.push_back(mk(13'h40, 4'd9, 1'b1));
        tick();
        bus_b.job_valid = 1'b0;
        tick();
        chk("to_start", 64'(bus_b.gcn_start), 64'(1));
        soft_cnt = 0; soft_first = -1; vld_first = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus_b.gcn_soft_reset === 1'b1) begin
                soft_cnt++;
                if (soft_first < 0) soft_first = k;
            end
            if (bus_b.res_valid === 1'b1 && vld_first < 0) vld_first = k;
        end
        chk("to_soft_cycle", 64'(soft_first), 64'(17));
        chk("to_soft_pulses", 64'(soft_cnt), 64'(1));
        chk("to_valid_cycle", 64'(vld_first), 64'(18));
        chk("to_valid_held", 64'(bus_b.res_valid), 64'(1));
        chk("to_sb_has_entry", 64'(sb_b.size() != 0), 64'(1));
        if (sb_b.size() != 0) begin
            eb = sb_b.pop_front();
            chk("to_res_id", 64'(bus_b.res_id), 64'(eb.job.id));
            chk("to_res_data", 64'(bus_b.res_data), 64'(eb.data));
            chk("to_res_timeout", 64'(bus_b.res_timeout), 64'(eb.to));
        end
        bus_b.res_ready = 1'b1;
        tick();
        bus_b.res_ready = 1'b0;
        chk("to_valid_drop", 64'(bus_b.res_valid), 64'(0));
        chk("to_busy_idle", 64'(bus_b.busy), 64'(0));

        // Reset while a job runs with two more queued.
        for (int k = 0; k < 3; k++) begin
            bus_a.job_valid = 1'b1;
            bus_a.job_base  = 13'h300 + 13'(k);
            bus_a.job_id    = 4'(10 + k);
            sb.push_back(mk(13'h300 + 13'(k), 4'(10 + k), 1'b0));
            tick();
            if (k == 1) chk("rst_case_start", 64'(bus_a.gcn_start), 64'(1));
        end
        bus_a.job_valid = 1'b0;
        chk("rst_case_busy", 64'(bus_a.busy), 64'(1));
        tick();
        reset = 1'b0;
        #1;
        check_reset_outputs("midrun");
        sb.delete();
        tick();
        check_reset_outputs("midrun_hold");
        reset = 1'b1;
        start_cnt = 0; vld_first = -1; soft_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus_a.gcn_start === 1'b1) start_cnt++;
            if (bus_a.gcn_soft_reset === 1'b1) soft_cnt++;
            if (bus_a.res_valid === 1'b1 && vld_first < 0) vld_first = k;
        end
        chk("post_rst_starts", 64'(start_cnt), 64'(0));
        chk("post_rst_soft", 64'(soft_cnt), 64'(0));
        chk("post_rst_valid", 64'(vld_first), 64'(-1));
        chk("post_rst_busy", 64'(bus_a.busy), 64'(0));
        chk("post_rst_ready", 64'(bus_a.job_ready), 64'(1));
        chk("sb_drained", 64'(sb.size()), 64'(0));
        chk("sb_b_drained", 64'(sb_b.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcn_job_scheduler.md
GCN_JOB_SCHEDULER -- requirements
Module: gcn_job_scheduler

Interface
REQ-001 SHALL have parameter FEATURE_ROWS, default 6: number of per-node results returned by the GCN core.
REQ-002 SHALL have parameter MAX_ADDRESS_WIDTH, default 2: width of each per-node argmax result.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 13: feature-memory address width.
REQ-004 SHALL have parameter ID_WIDTH, default 4: job tag width.
REQ-005 SHALL have parameter JOB_DEPTH, default 4 (power of two, >= 2): job queue entries.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum RUN cycles before abort.
REQ-007 SHALL have the following ports:
- clk  input  1  sole clock, all state on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- job_valid  input  1  job request valid.
- job_ready  output  1  queue can accept a job.
- job_base  input  ADDRESS_WIDTH  graph base address in feature memory.
- job_id  input  ID_WIDTH  job tag.
- gcn_start  output  1  one-cycle start pulse to the GCN core.
- gcn_soft_reset  output  1  one-cycle abort pulse to the GCN core.
- gcn_done  input  1  GCN core done (level).
- gcn_read_address  input  ADDRESS_WIDTH  core-relative read address.
- mem_address  output  ADDRESS_WIDTH  absolute memory address.
- gcn_result  input  FEATURE_ROWS x MAX_ADDRESS_WIDTH  core argmax results.
- res_valid  output  1  result valid.
- res_ready  input  1  result consumer ready.
- res_id  output  ID_WIDTH  tag of the reported job.
- res_data  output  FEATURE_ROWS x MAX_ADDRESS_WIDTH  captured results.
- res_timeout  output  1  the reported job was aborted.
- busy  output  1  FSM not in IDLE, or queue not empty.

Function
REQ-008 Job accepted when job_valid && job_ready; job_ready = !queue_full; a push is refused when full even if a pop occurs in the same cycle.
REQ-009 Queue SHALL be FIFO ordered; pointers wrap modulo JOB_DEPTH; the count SHALL be able to represent JOB_DEPTH.
REQ-010 FSM states: IDLE, LAUNCH, RUN, ABORT, REPORT.
REQ-011 IDLE -> LAUNCH when the queue is non-empty; LAUNCH pops the head, latches base/id, and drives gcn_start=1 for exactly that cycle; LAUNCH -> RUN.
REQ-012 A job pushed into an empty queue in cycle N SHALL produce gcn_start in cycle N+2.
REQ-013 RUN SHALL ignore gcn_done in its first cycle (stale level from the previous job) and sample it from the second RUN cycle on.
REQ-014 RUN with sampled gcn_done=1 -> REPORT; gcn_result captured into res_data on that edge; res_timeout=0.
REQ-015 The RUN cycle counter starts at 0 on RUN entry; if it reaches TIMEOUT_CYCLES-1 without gcn_done, FSM SHALL go to ABORT; done in that same cycle wins over timeout.
REQ-016 ABORT drives gcn_soft_reset=1 for exactly one cycle, sets res_data to all zeros and res_timeout=1, then goes to REPORT.
REQ-017 REPORT holds res_valid=1 with res_id/res_data/res_timeout stable until res_ready; on the handshake cycle -> IDLE (one-cycle bubble before the next LAUNCH).
REQ-018 mem_address = latched base + gcn_read_address, truncated modulo 2^ADDRESS_WIDTH; it equals gcn_read_address when the FSM is in IDLE.
REQ-019 gcn_done outside RUN SHALL be ignored; the queue SHALL keep accepting jobs in every state.

Reset
REQ-020 reset=0 SHALL asynchronously force IDLE, empty the queue, and clear the counter, latched base/id, res_data, res_id and res_timeout.
REQ-021 During reset: gcn_start=0, gcn_soft_reset=0, res_valid=0, busy=0, job_ready=1.
REQ-022 Reset mid-RUN SHALL discard the in-flight and queued jobs with no result reported.
REQ-023 gcn_soft_reset SHALL NOT be asserted because of a reset.

Structure
REQ-024 Package gcn_sched_pkg SHALL hold the state enum, the queue-entry struct {base, id} and the default parameter constants.
REQ-025 The queue SHALL be a separate sub-module, gcn_job_fifo (depth JOB_DEPTH, push/pop/full/empty).

Verification
REQ-026 One job (base=0x100, id=3), gcn_done raised 20 cycles after start -> gcn_start at N+2, mem_address=0x100+gcn_read_address, res_id=3, res_timeout=0, res_data = gcn_result.
REQ-027 Push 5 jobs back-to-back, JOB_DEPTH=4 -> job_ready=0 on the 5th, only 4 accepted; results come out in order, ids 0,1,2,3.
REQ-028 gcn_done never raised, TIMEOUT_CYCLES=16 -> ABORT after 16 RUN cycles, one gcn_soft_reset pulse, res_timeout=1, res_data=0.
REQ-029 res_ready held 0 for 10 cycles in REPORT -> res_* stable, no new gcn_start until the handshake, then next LAUNCH 2 cycles later.
REQ-030 base=0x1FF0, gcn_read_address=0x20 -> mem_address=0x0010 (wrap); gcn_done held high across jobs -> second job not completed in its first RUN cycle.
REQ-031 reset dropped mid-RUN with 2 jobs queued -> all outputs at reset values, busy=0, no res_valid after reset release.
